// File: rtl/seq_alu.sv
// Multi-cycle ALU: one operation per start, binary ops in one EXEC step, BCD ADC/SBC
// processed one nibble per clock. Result and {N,V,Z,C} flags are registered.
module seq_alu #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          DECIMAL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             vin,
  input  logic             dmode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned NibW = (Nib > 1) ? $clog2(Nib) : 1;
  localparam logic [NibW-1:0] LastNib = NibW'(Nib - 1);

  localparam logic [3:0] OpOra = 4'd0;
  localparam logic [3:0] OpAnd = 4'd1;
  localparam logic [3:0] OpEor = 4'd2;
  localparam logic [3:0] OpAdc = 4'd3;
  localparam logic [3:0] OpSbc = 4'd4;
  localparam logic [3:0] OpAsl = 4'd5;
  localparam logic [3:0] OpLsr = 4'd6;
  localparam logic [3:0] OpRol = 4'd7;
  localparam logic [3:0] OpRor = 4'd8;
  localparam logic [3:0] OpCmp = 4'd9;

  typedef enum logic [1:0] {StIdle, StExec, StAdj, StDone} state_e;

  state_e state_q, state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q, vin_q, dec_q;
  logic [NibW-1:0]  nib_q;
  logic             carry_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  // Binary datapath
  logic [WIDTH-1:0] b_eff, bin_res, diff;
  logic [WIDTH:0]   sum;
  logic             add_v, bin_c, bin_v;
  logic [3:0]       bin_flags;

  always_comb begin
    b_eff   = (op_q == OpSbc) ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};
    add_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    diff    = a_q - b_q;
    bin_res = a_q;
    bin_c   = cin_q;
    bin_v   = vin_q;
    case (op_q)
      OpOra: bin_res = a_q | b_q;
      OpAnd: bin_res = a_q & b_q;
      OpEor: bin_res = a_q ^ b_q;
      OpAdc, OpSbc: begin
        bin_res = sum[WIDTH-1:0];
        bin_c   = sum[WIDTH];
        bin_v   = add_v;
      end
      OpAsl: begin
        bin_res = {a_q[WIDTH-2:0], 1'b0};
        bin_c   = a_q[WIDTH-1];
      end
      OpLsr: begin
        bin_res = {1'b0, a_q[WIDTH-1:1]};
        bin_c   = a_q[0];
      end
      OpRol: begin
        bin_res = {a_q[WIDTH-2:0], cin_q};
        bin_c   = a_q[WIDTH-1];
      end
      OpRor: begin
        bin_res = {cin_q, a_q[WIDTH-1:1]};
        bin_c   = a_q[0];
      end
      OpCmp: begin
        bin_res = diff;
        bin_c   = (a_q >= b_q);
      end
      default: ;
    endcase
    bin_flags = {bin_res[WIDTH-1], bin_v, (bin_res == '0), bin_c};
  end

  // Decimal nibble step; carry_q holds carry for ADC and borrow for SBC
  logic [NibW-1:0]  idx;
  logic [NibW+1:0]  shamt;
  logic [3:0]       a_n, b_n, digit;
  logic [4:0]       s;
  logic             is_sbc, c_in_n, c_out_n, dec_c;
  logic [WIDTH-1:0] acc_nxt;
  logic [3:0]       dec_flags;

  always_comb begin
    is_sbc = (op_q == OpSbc);
    idx    = (state_q == StExec) ? '0 : nib_q;
    shamt  = {idx, 2'b00};
    a_n    = 4'(a_q >> shamt);
    b_n    = 4'(b_q >> shamt);
    c_in_n = (state_q == StExec) ? (is_sbc ? ~cin_q : cin_q) : carry_q;
    if (is_sbc) begin
      s       = {1'b0, a_n} - {1'b0, b_n} - {4'b0, c_in_n};
      c_out_n = s[4];
      digit   = s[4] ? (s[3:0] - 4'd6) : s[3:0];
    end else begin
      s       = {1'b0, a_n} + {1'b0, b_n} + {4'b0, c_in_n};
      c_out_n = (s > 5'd9);
      digit   = c_out_n ? (s[3:0] + 4'd6) : s[3:0];
    end
    acc_nxt = acc_q;
    for (int unsigned i = 0; i < Nib; i++) begin
      if (NibW'(i) == idx) acc_nxt[4*i +: 4] = digit;
    end
    dec_c     = is_sbc ? ~c_out_n : c_out_n;
    dec_flags = {acc_nxt[WIDTH-1], add_v, (acc_nxt == '0), dec_c};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StExec;
      end
      StExec: state_d = dec_q ? StAdj : StDone;
      StAdj:  if (idx == LastNib) state_d = StDone;
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      vin_q    <= 1'b0;
      dec_q    <= 1'b0;
      nib_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            cin_q   <= cin;
            vin_q   <= vin;
            dec_q   <= DECIMAL_EN && dmode && ((op == OpAdc) || (op == OpSbc));
            nib_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
          end
        end
        StExec: begin
          if (dec_q) begin
            acc_q   <= acc_nxt;
            carry_q <= c_out_n;
            nib_q   <= NibW'(1);
          end else begin
            result_q <= bin_res;
            flags_q  <= bin_flags;
          end
        end
        StAdj: begin
          acc_q   <= acc_nxt;
          carry_q <= c_out_n;
          nib_q   <= nib_q + 1'b1;
          if (idx == LastNib) begin
            result_q <= acc_nxt;
            flags_q  <= dec_flags;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=8 and WIDTH=16: expectations are queued at issue
// and popped by per-instance monitors on each done pulse.
module tb_seq_alu;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [3:0]  op_in = '0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        cin_in = 1'b0, vin_in = 1'b0, dm_in = 1'b0;

  logic        busy8, done8, busy16, done16;
  logic [7:0]  result8;
  logic [15:0] result16;
  logic [3:0]  flags8, flags16;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done8_cnt = 0;
  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.WIDTH(8), .DECIMAL_EN(1'b1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op_in), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .vin(vin_in), .dmode(dm_in), .busy(busy8), .done(done8),
    .result(result8), .flags(flags8)
  );

  seq_alu #(.WIDTH(16), .DECIMAL_EN(1'b1)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op_in), .a(a_in), .b(b_in),
    .cin(cin_in), .vin(vin_in), .dmode(dm_in), .busy(busy16), .done(done16),
    .result(result16), .flags(flags16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: returns {N,V,Z,C,result}
  function automatic logic [35:0] model(input int w, input logic [3:0] o,
                                        input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic vi, input logic dm);
    logic [31:0] mask, r, bb;
    logic [32:0] s;
    logic        n, v, z, c;
    int          carry, an, bn, t;
    mask = 32'((33'h1 << w) - 33'h1);
    r = av;
    c = ci;
    v = vi;
    case (o)
      4'd0: r = av | bv;
      4'd1: r = av & bv;
      4'd2: r = av ^ bv;
      4'd3, 4'd4: begin
        bb = (o == 4'd4) ? (~bv & mask) : bv;
        s  = {1'b0, av} + {1'b0, bb} + 33'(ci);
        r  = s[31:0] & mask;
        c  = s[w];
        v  = (av[w-1] == bb[w-1]) && (r[w-1] != av[w-1]);
        if (dm) begin
          carry = (o == 4'd3) ? int'(ci) : int'(!ci);
          r = '0;
          for (int i = 0; i < w / 4; i++) begin
            an = int'((av >> (4 * i)) & 32'hF);
            bn = int'((bv >> (4 * i)) & 32'hF);
            if (o == 4'd3) begin
              t = an + bn + carry;
              if (t > 9) begin t = t + 6; carry = 1; end else carry = 0;
            end else begin
              t = an - bn - carry;
              if (t < 0) begin t = t - 6; carry = 1; end else carry = 0;
            end
            r = r | (32'(t & 15) << (4 * i));
          end
          c = (o == 4'd3) ? (carry == 1) : (carry == 0);
        end
      end
      4'd5: begin r = (av << 1) & mask; c = av[w-1]; end
      4'd6: begin r = av >> 1; c = av[0]; end
      4'd7: begin r = ((av << 1) | 32'(ci)) & mask; c = av[w-1]; end
      4'd8: begin r = (av >> 1) | (32'(ci) << (w - 1)); c = av[0]; end
      4'd9: begin r = (av - bv) & mask; c = (av >= bv); end
      default: ;
    endcase
    n = r[w-1];
    z = (r == '0);
    return {n, v, z, c, r};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      done8_cnt++;
      if (q8.size() == 0) check("done8_spurious", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("result8", 32'(result8), e.r);
        check("flags8", 32'(flags8), 32'(e.f));
        check("latency8", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) check("done16_spurious", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        check("result16", 32'(result16), e.r);
        check("flags16", 32'(flags16), 32'(e.f));
        check("latency16", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge with the chosen DUT idle; returns at a negedge with it idle again
  task automatic issue(input int w, input logic [3:0] o, input logic [15:0] av,
                       input logic [15:0] bv, input logic ci, input logic vi, input logic dm,
                       input logic [31:0] er, input logic [3:0] ef, input int lat);
    exp_t e;
    int   i;
    op_in = o; a_in = av; b_in = bv; cin_in = ci; vin_in = vi; dm_in = dm;
    if (w == 8) start8 = 1'b1; else start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    e.r = er; e.f = ef; e.cyc = cyc + lat;
    if (w == 8) begin check("busy8_accept", 32'(busy8), 32'd1); q8.push_back(e); end
    else begin check("busy16_accept", 32'(busy16), 32'd1); q16.push_back(e); end
    for (i = 0; i < 40 && ((w == 8) ? q8.size() : q16.size()) != 0; i++) @(negedge clk);
    if (((w == 8) ? q8.size() : q16.size()) != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      q8.delete();
      q16.delete();
    end
    for (i = 0; i < 10 && ((w == 8) ? busy8 : busy16); i++) @(negedge clk);
    if ((w == 8) ? busy8 : busy16) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue_rand(input int w);
    logic [3:0]  o;
    logic [15:0] av, bv;
    logic        ci, vi, dm;
    logic [35:0] m;
    o  = 4'($urandom_range(0, 15));
    av = (w == 8) ? 16'($urandom_range(0, 255)) : 16'($urandom);
    bv = (w == 8) ? 16'($urandom_range(0, 255)) : 16'($urandom);
    ci = 1'($urandom); vi = 1'($urandom); dm = 1'($urandom);
    m  = model(w, o, 32'(av), 32'(bv), ci, vi, dm);
    issue(w, o, av, bv, ci, vi, dm, m[31:0], m[35:32],
          (dm && (o == 4'd3 || o == 4'd4)) ? w / 4 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_flags", 32'(flags8), 32'd0);
    reset = 1'b0;

    // Accepted on the very first edge after reset release
    issue(8, 4'd0, 16'h00, 16'h84, 1'b0, 1'b0, 1'b0, 32'h84, 4'b1000, 1);
    issue(8, 4'd3, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b0, 32'h80, 4'b1100, 1);
    issue(8, 4'd3, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b0, 32'h00, 4'b0011, 1);
    issue(8, 4'd3, 16'h58, 16'h46, 1'b1, 1'b0, 1'b1, 32'h05, 4'b0101, 2);
    issue(8, 4'd4, 16'h12, 16'h21, 1'b1, 1'b0, 1'b1, 32'h91, 4'b1000, 2);
    issue(16, 4'd8, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h8000, 4'b1001, 1);
    issue(16, 4'd3, 16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 32'h0000, 4'b0011, 4);
    issue(8, 4'd9, 16'h10, 16'h20, 1'b0, 1'b1, 1'b0, 32'hF0, 4'b1100, 1);
    issue(8, 4'd5, 16'h81, 16'h00, 1'b0, 1'b0, 1'b0, 32'h02, 4'b0001, 1);

    for (int k = 0; k < 40; k++) issue_rand(8);
    for (int k = 0; k < 40; k++) issue_rand(16);

    // start held high throughout busy: exactly one operation
    cnt0 = done8_cnt;
    op_in = 4'd2; a_in = 16'h0F; b_in = 16'hFF; cin_in = 1'b1; vin_in = 1'b0; dm_in = 1'b0;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    begin
      exp_t e;
      e.r = 32'hF0; e.f = 4'b1001; e.cyc = cyc + 1;
      q8.push_back(e);
    end
    for (int i = 0; i < 10 && busy8; i++) @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_single_done", 32'(done8_cnt - cnt0), 32'd1);

    // Reset while in ADJ aborts with no done pulse
    cnt0 = done8_cnt;
    op_in = 4'd3; a_in = 16'h58; b_in = 16'h46; cin_in = 1'b1; dm_in = 1'b1;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_result", 32'(result8), 32'd0);
    check("abort_flags", 32'(flags8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done8_cnt - cnt0), 32'd0);
    issue(8, 4'd6, 16'h03, 16'h00, 1'b0, 1'b1, 1'b0, 32'h01, 4'b0101, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, meaning operand/result width in bits; legal values are multiples of 4 from 8 to 32.
REQ-002 The block SHALL have the parameter DECIMAL_EN, default 1, meaning BCD mode is present; when 0, dmode SHALL be ignored.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have the port start, input, 1 bit: request a new operation.
REQ-006 The block SHALL have the port op, input, 4 bits: 0 ORA, 1 AND, 2 EOR, 3 ADC, 4 SBC, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 CMP, 10-15 PASS.
REQ-007 The block SHALL have the ports a and b, input, WIDTH bits each: operands; shifts use a only.
REQ-008 The block SHALL have the ports cin and vin, input, 1 bit each: incoming C and V flags.
REQ-009 The block SHALL have the port dmode, input, 1 bit: decimal mode for ADC/SBC.
REQ-010 The block SHALL have the port busy, output, 1 bit: an operation is in progress, and start is ignored while it is high.
REQ-011 The block SHALL have the port done, output, 1 bit: a one-cycle pulse indicating that the result and flags were updated.
REQ-012 The block SHALL have the port result, output, WIDTH bits: the registered result.
REQ-013 The block SHALL have the port flags, output, 4 bits: {N,V,Z,C}, registered.

Function
REQ-014 The state machine SHALL have the states IDLE, EXEC, ADJ and DONE.
REQ-015 In IDLE with start=1 at edge k, the block SHALL latch op, a, b, cin, vin, dmode and move to EXEC, with busy=1 from k.
REQ-016 In EXEC at edge k+1, a binary operation SHALL compute the result and flags, load result and flags, and go to DONE.
REQ-017 In DONE, done=1 and busy=1 for one cycle, and the block SHALL return to IDLE on the next edge; start is accepted only from IDLE.
REQ-018 Decimal ADC/SBC (dmode=1, DECIMAL_EN=1) SHALL process nibble 0 at EXEC, then one nibble per edge in ADJ, then move to DONE; done SHALL go high after edge k+WIDTH/4.
REQ-019 result and flags SHALL hold their previous values until the DONE transition, and SHALL hold their new values after DONE until the next DONE.
REQ-020 ORA, AND and EOR SHALL produce the bitwise result, with N=MSB, Z=(result==0), V=vin and C=cin.
REQ-021 ADC SHALL compute a+b+cin, and SBC SHALL compute a+~b+cin, each mod 2^WIDTH, with C=carry-out and V=signed overflow of that binary sum.
REQ-022 Decimal ADC, per nibble: the block SHALL form s=a_n+b_n+carry, and if s>9 then add 6 and set carry; C SHALL be the final carry.
REQ-023 Decimal SBC, per nibble: the block SHALL form d=a_n-b_n-borrow (borrow=~cin initially), and if d<0 then subtract 6 (mod 16) and set borrow; C SHALL be ~final borrow.
REQ-024 In decimal mode, N and Z SHALL come from the BCD result, V SHALL come from the binary sum of REQ-021, and non-BCD digits SHALL need no special handling.
REQ-025 Shifts SHALL behave as follows, with V=vin and N/Z from the result:
- ASL: shift in 0, C=old MSB.
- LSR: shift in 0, C=old LSB.
- ROL: shift in cin, C=old MSB.
- ROR: shift in cin, C=old LSB.
REQ-026 CMP SHALL set result=a-b mod 2^WIDTH, C=(a>=b unsigned), Z=(a==b), N=MSB of the difference and V=vin.
REQ-027 PASS SHALL set result=a, N/Z from a, V=vin and C=cin.
REQ-028 A start arriving in the same cycle as DONE SHALL be ignored, and the requester SHALL re-assert it after busy=0.

Reset
REQ-029 While reset=1, the block SHALL immediately force state=IDLE, busy=0, done=0, result=0, flags=4'b0000, and clear the latched operands and nibble counter.
REQ-030 A reset asserted during EXEC, ADJ or DONE SHALL abort the operation without producing a done pulse, and the outputs SHALL take the REQ-029 values.
REQ-031 The first start SHALL be accepted at the first rising edge on which reset=0.

Verification
REQ-032 ORA scenario: op=0, a=8'h00, b=8'h84, cin=0, vin=0 -> done one cycle after EXEC, result=8'h84, flags N=1, Z=0, V=0, C=0.
REQ-033 Binary ADC scenario: a=8'h7F, b=8'h01, cin=0 -> result=8'h80, N=1, V=1, Z=0, C=0; and a=8'hFF, b=8'h01 -> result=8'h00, Z=1, C=1.
REQ-034 Decimal scenario: ADC dmode=1 with a=8'h58, b=8'h46, cin=1 -> result=8'h05, C=1, done after edge k+2; and SBC with a=8'h12, b=8'h21, cin=1 -> result=8'h91, C=0.
REQ-035 WIDTH=16 scenario: ROR with a=16'h0001, cin=1 -> result=16'h8000, C=1, N=1; and decimal ADC 16'h9999+16'h0001 -> result=16'h0000, C=1, Z=1, done after edge k+4.
REQ-036 Busy scenario: start held high during busy -> exactly one operation, and no second done until a new start arrives in IDLE.
REQ-037 Reset scenario: reset pulsed during ADJ -> busy=0, done never pulses, result=0, flags=0 within the reset cycle, and the next start behaves normally.
